// File: rtl/stream_deser_pkg.sv
// Shared types and helpers for the stream deserializer.
package stream_deser_pkg;

  typedef enum logic {S_FILL, S_HOLD} state_t;

  // Width needed to hold a word count in the range 0..ratio.
  function automatic int cnt_w(input int ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/stream_deser.sv
// Width-expanding deserializer: packs RATIO input words into one frame,
// with early close on flush and a valid/ready output stage.
module stream_deser
  import stream_deser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [WIDTH*RATIO-1:0]     out_data,
  output logic [cnt_w(RATIO)-1:0]    out_count,
  input  logic                       out_ready
);

  localparam int CW = cnt_w(RATIO);
  localparam int FW = WIDTH * RATIO;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   words_next;
  logic [FW-1:0]   slot_buf;
  logic [FW-1:0]   slot_next;
  logic            accept;
  logic            flush_s;
  logic            close;

  // A held frame blocks intake unless it retires this same cycle.
  assign in_ready   = !rst && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign flush_s    = flush && in_ready;
  assign words_next = cnt + CW'(accept);
  assign close      = (accept && (cnt == CW'(RATIO - 1)))
                   || (flush_s && (words_next != '0));

  always_comb begin
    slot_next = slot_buf;
    if (accept) slot_next[int'(cnt)*WIDTH +: WIDTH] = in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FILL;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FILL: if (close) state_next = S_HOLD;
      S_HOLD: if (out_ready && !close) state_next = S_FILL;
      default: state_next = S_FILL;
    endcase
  end

  always_comb begin
    out_valid = (state == S_HOLD);
  end

  // Closing a frame hands the merged buffer to the output and starts empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      slot_buf  <= '0;
      out_data  <= '0;
      out_count <= '0;
    end else if (close) begin
      cnt       <= '0;
      slot_buf  <= '0;
      out_data  <= slot_next;
      out_count <= words_next;
    end else if (accept) begin
      cnt       <= cnt + CW'(1);
      slot_buf  <= slot_next;
    end
  end

endmodule

// File: tb/tb_stream_deser.sv
// Self-checking bench for stream_deser: directed scenarios plus random traffic
// against a frame-level reference model built from word queues.
module tb_stream_deser;

  localparam int WIDTH = 8;
  localparam int RATIO = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic [WIDTH-1:0]       in_data;
  logic                   in_ready;
  logic                   flush;
  logic                   out_valid;
  logic [WIDTH*RATIO-1:0] out_data;
  logic [2:0]             out_count;
  logic                   out_ready;

  int vec_count = 0;
  int err_count = 0;

  logic [WIDTH-1:0]       frame_q[$];
  bit                     m_valid;
  logic [WIDTH*RATIO-1:0] m_data;
  int                     m_count;

  stream_deser #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
    .out_data(out_data), .out_count(out_count), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_count++;
    if (obs !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH*RATIO-1:0] pack(input logic [WIDTH-1:0] q[$]);
    logic [WIDTH*RATIO-1:0] r = '0;
    for (int k = 0; k < q.size(); k++) r = r | ((WIDTH*RATIO)'(q[k]) << (k * WIDTH));
    return r;
  endfunction

  // Drive one cycle of inputs from a falling edge, check outputs against the
  // model, then advance the model across the rising edge.
  task automatic applyStimulus(input bit v, input logic [WIDTH-1:0] d, input bit f, input bit r);
    bit rdy, acc, fl;
    in_valid  = v;
    in_data   = d;
    flush     = f;
    out_ready = r;
    #1;
    rdy = !m_valid || r;
    checkOutput("in_ready", in_ready, rdy);
    checkOutput("out_valid", out_valid, m_valid);
    if (m_valid) begin
      checkOutput("out_data", out_data, m_data);
      checkOutput("out_count", out_count, m_count);
    end
    @(posedge clk);
    acc = v && rdy;
    fl  = f && rdy;
    if (m_valid && r) m_valid = 0;
    if (acc) frame_q.push_back(d);
    if (frame_q.size() == RATIO || (fl && frame_q.size() >= 1)) begin
      m_data  = pack(frame_q);
      m_count = frame_q.size();
      m_valid = 1;
      frame_q.delete();
    end
    @(negedge clk);
  endtask

  // Reset raised between edges; outputs must clear without waiting for a clock.
  task automatic doReset();
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_count", out_count, 3'd0);
    checkOutput("rst_out_data", out_data, '0);
    checkOutput("rst_in_ready", in_ready, 1'b0);
    frame_q.delete();
    m_valid = 0;
    m_data  = '0;
    m_count = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; in_valid = 0; in_data = '0; flush = 0; out_ready = 1;
    @(negedge clk);
    doReset();

    // Single full frame
    applyStimulus(1, 8'h11, 0, 1);
    applyStimulus(1, 8'h22, 0, 1);
    applyStimulus(1, 8'h33, 0, 1);
    applyStimulus(1, 8'h44, 0, 1);
    checkOutput("tp1_valid", out_valid, 1'b1);
    checkOutput("tp1_data", out_data, 32'h44332211);
    checkOutput("tp1_count", out_count, 3'd4);
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("tp1_drop", out_valid, 1'b0);

    // Continuous stream, no bubbles
    for (int i = 1; i <= 8; i++) applyStimulus(1, 8'(i), 0, 1);
    checkOutput("tp2_data", out_data, 32'h08070605);
    applyStimulus(0, 8'h00, 0, 1);

    // Flush of a partial frame, then a lone flush that must do nothing
    applyStimulus(1, 8'hA1, 0, 1);
    applyStimulus(1, 8'hA2, 0, 1);
    applyStimulus(0, 8'h00, 1, 1);
    checkOutput("tp3_data", out_data, 32'h0000A2A1);
    checkOutput("tp3_count", out_count, 3'd2);
    applyStimulus(0, 8'h00, 1, 1);
    checkOutput("tp3_noframe", out_valid, 1'b0);

    // Backpressure on a held frame, release together with a new word
    for (int i = 0; i < 4; i++) applyStimulus(1, 8'hB0 + 8'(i), 0, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 8'h99, 0, 0);
      checkOutput("tp4_hold", out_data, 32'hB3B2B1B0);
    end
    applyStimulus(1, 8'h55, 0, 1);
    applyStimulus(1, 8'hC1, 0, 1);
    applyStimulus(1, 8'hC2, 0, 1);
    applyStimulus(1, 8'hC3, 0, 1);
    checkOutput("tp4_next", out_data, 32'hC3C2C155);

    // Flush together with a word
    applyStimulus(1, 8'h66, 0, 1);
    applyStimulus(1, 8'h77, 1, 1);
    checkOutput("tp5_data", out_data, 32'h00007766);
    checkOutput("tp5_count", out_count, 3'd2);
    applyStimulus(0, 8'h00, 0, 1);

    // Reset mid-frame discards everything
    applyStimulus(1, 8'hE1, 0, 1);
    applyStimulus(1, 8'hE2, 0, 1);
    applyStimulus(1, 8'hE3, 0, 1);
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1, 8'hD0 + 8'(i), 0, 1);
    checkOutput("tp6_data", out_data, 32'hD3D2D1D0);
    checkOutput("tp6_count", out_count, 3'd4);

    // Random traffic
    for (int i = 0; i < 600; i++)
      applyStimulus(($urandom % 4) != 0, 8'($urandom), ($urandom % 8) == 0, ($urandom % 4) != 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
